if_id_stage: RTL and testbench
==============================

# if_id_stage

Pipeline register and load-use hazard unit between the fetch stage and the decode stage of the 5-stage pipeline.
- Captures the fetched `instruction` and `noBrPC` each cycle and presents them to decode as `decInstruction` / `dec_pc`.
- Detects a load-use dependency against the instruction in EX, holds the PC and the IF/ID register, and injects bubbles into ID/EX.
- Optionally squashes the fetched slot on a decode-resolved redirect.

## Interface
Parameters:
- `STALL_CYCLES`, default 1: bubbles inserted per load-use hazard (1..3).
- `FLUSH_ON_BRANCH`, default 0: 0 keeps branch-delay-slot semantics; 1 squashes the slot after a redirect.
- `NOP_INSTR`, default 32'h8B1F03FF: encoding loaded on reset and flush (ADD X31,X31,X31).

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `instruction` in 32: instruction from fetch.
- `noBrPC` in 64: PC+4 from fetch.
- `br_redirect` in 1: decode asserts when BrTaken or BR_op is active this cycle.
- `ex_mem_read` in 1: instruction in EX is a load (LDUR).
- `ex_rd` in 5: destination register of the instruction in EX.
- `decInstruction` out 32: registered instruction to decode.
- `dec_pc` out 64: registered PC+4 of `decInstruction`.
- `dec_valid` out 1: 0 when `decInstruction` is a reset or flush NOP.
- `pc_write_en` out 1: 0 freezes the program counter.
- `bubble` out 1: 1 forces ID/EX control signals to zero.
- `stall_count` out 2: remaining stall cycles; debug only.

## Operation
Source fields of `decInstruction`:
- Rn = [9:5]; Rm = [20:16].
- Rt = [4:0] counts as a source only for CBZ ([31:24]=8'hB4) and STUR ([31:21]=11'h7C0).

Hazard:
- `hazard` = `dec_valid` & `ex_mem_read` & (`ex_rd` != 31) & (`ex_rd` matches any active source field).
- Evaluated in RUN only.

FSM with states RUN and STALL:
- RUN, no hazard:
  - Register loads `instruction` / `noBrPC`; `dec_valid` <= 1.
  - `pc_write_en` = 1; `bubble` = 0.
- RUN, hazard:
  - `pc_write_en` = 0 and `bubble` = 1 combinationally; register holds.
  - If `STALL_CYCLES` > 1: go to STALL with `stall_count` <= `STALL_CYCLES` - 1.
  - Otherwise remain in RUN.
- STALL:
  - `pc_write_en` = 0; `bubble` = 1; register holds.
  - `stall_count` decrements each cycle; hazard logic is ignored.
  - When `stall_count` = 1: return to RUN and `stall_count` <= 0.
- Flush (`FLUSH_ON_BRANCH` = 1, `br_redirect` = 1, RUN, no hazard):
  - Register loads `NOP_INSTR`; `dec_pc` <= `noBrPC`; `dec_valid` <= 0.
  - `pc_write_en` = 1.
- `FLUSH_ON_BRANCH` = 0: `br_redirect` is ignored, so the slot instruction executes.

Priority (highest first): reset > STALL state > hazard > flush > normal load.
- Hazard and `br_redirect` in the same cycle: the stall wins and the redirect is dropped. Decode re-asserts the redirect after the stall clears.

## Timing
Reset values (after a posedge with `reset` = 1):
- `decInstruction` = `NOP_INSTR`; `dec_pc` = 0; `dec_valid` = 0.
- State = RUN; `stall_count` = 0.
- `pc_write_en` = 1; `bubble` = 0.
- Reset asserted mid-stall aborts the stall at that edge.

Output timing:
- `decInstruction`, `dec_pc`, `dec_valid`, `stall_count`: registered, 1-cycle latency from fetch.
- `pc_write_en`, `bubble`: combinational from state, `decInstruction`, `ex_mem_read`, `ex_rd`. These are valid in the same cycle as the hazard and reach the PC before the next edge.

Stall length:
- Exactly `STALL_CYCLES` cycles of `pc_write_en` = 0 per hazard.
- The dependent instruction stays in decode for `STALL_CYCLES` + 1 cycles.
- Back-to-back hazards after a stall are re-evaluated normally in RUN.
- An `ex_rd` of 31 (XZR) never stalls.

## Test plan
- Reset: hold `reset` for 2 cycles with `instruction` = 32'hFFFFFFFF -> `decInstruction` = 32'h8B1F03FF, `dec_valid` = 0, `dec_pc` = 0, `pc_write_en` = 1.
- Straight-line flow: 4 instructions with `noBrPC` = 4, 8, 12, 16 and no loads in EX -> each appears on `decInstruction` / `dec_pc` one cycle later; `bubble` never asserts.
- Load-use on Rn: `decInstruction` = ADD X2,X1,X3 with `ex_mem_read` = 1, `ex_rd` = 1 -> `pc_write_en` = 0 and `bubble` = 1 for 1 cycle, register held; the next cycle (`ex_mem_read` = 0) advances. Repeat with `STALL_CYCLES` = 3 -> 3 stall cycles, `stall_count` 2, 1, 0.
- Store/CBZ Rt and XZR: STUR X5,[X6] with `ex_rd` = 5 -> stall. CBZ X31 with `ex_rd` = 31 -> no stall. ADD X5,X6,X7 with `ex_rd` = 5 -> no stall (Rd is not a source).
- Flush: with `FLUSH_ON_BRANCH` = 1, assert `br_redirect` for 1 cycle -> next `decInstruction` = NOP, `dec_valid` = 0. With `FLUSH_ON_BRANCH` = 0 -> the slot instruction is loaded.
- Simultaneous and reset cases: hazard and `br_redirect` together -> stall, no flush. With `STALL_CYCLES` = 3, assert `reset` in the 2nd stall cycle -> the next cycle shows RUN, `pc_write_en` = 1, `stall_count` = 0.

Source files
------------

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection.
// Holds the fetched slot and the PC while a dependent instruction waits on a load in EX.
`timescale 1ns/1ps

module if_id_stage #(
  parameter int unsigned STALL_CYCLES    = 1,
  parameter int unsigned FLUSH_ON_BRANCH = 0,
  parameter logic [31:0] NOP_INSTR       = 32'h8B1F03FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [63:0] noBrPC,
  input  logic        br_redirect,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  output logic [31:0] decInstruction,
  output logic [63:0] dec_pc,
  output logic        dec_valid,
  output logic        pc_write_en,
  output logic        bubble,
  output logic [1:0]  stall_count
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic       FLUSH_EN     = (FLUSH_ON_BRANCH != 0);
  localparam logic       MULTI_STALL  = (STALL_CYCLES > 1);
  localparam logic [1:0] STALL_RELOAD = 2'(STALL_CYCLES - 1);
  localparam int         NUM_SRC      = 3;

  state_t      state_reg, state_next;
  logic [31:0] instr_reg, instr_next;
  logic [63:0] pc_reg, pc_next;
  logic        valid_reg, valid_next;
  logic [1:0]  count_reg, count_next;

  logic [4:0]         src_field [NUM_SRC];
  logic [NUM_SRC-1:0] src_active;
  logic [NUM_SRC-1:0] src_match;
  logic               rt_is_src;
  logic               hazard;

  // Rt is read (not written) only by CBZ and STUR.
  assign rt_is_src = (instr_reg[31:24] == 8'hB4) || (instr_reg[31:21] == 11'h7C0);

  assign src_field[0] = instr_reg[9:5];
  assign src_field[1] = instr_reg[20:16];
  assign src_field[2] = instr_reg[4:0];
  assign src_active   = {rt_is_src, 1'b1, 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_match[gi] = src_active[gi] && (src_field[gi] == ex_rd);
    end
  endgenerate

  // XZR is never a real producer, so a load into X31 cannot create a dependency.
  assign hazard = valid_reg && ex_mem_read && (ex_rd != 5'd31) && (|src_match);

  always_comb begin
    state_next  = state_reg;
    instr_next  = instr_reg;
    pc_next     = pc_reg;
    valid_next  = valid_reg;
    count_next  = count_reg;
    pc_write_en = 1'b1;
    bubble      = 1'b0;

    case (state_reg)
      RUN: begin
        if (hazard) begin
          pc_write_en = 1'b0;
          bubble      = 1'b1;
          if (MULTI_STALL) begin
            state_next = STALL;
            count_next = STALL_RELOAD;
          end
        end else if (FLUSH_EN && br_redirect) begin
          instr_next = NOP_INSTR;
          pc_next    = noBrPC;
          valid_next = 1'b0;
        end else begin
          instr_next = instruction;
          pc_next    = noBrPC;
          valid_next = 1'b1;
        end
      end

      STALL: begin
        pc_write_en = 1'b0;
        bubble      = 1'b1;
        if (count_reg <= 2'd1) begin
          state_next = RUN;
          count_next = 2'd0;
        end else begin
          count_next = count_reg - 2'd1;
        end
      end

      default: begin
        state_next = RUN;
        count_next = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      instr_reg <= NOP_INSTR;
      pc_reg    <= 64'd0;
      valid_reg <= 1'b0;
      count_reg <= 2'd0;
    end else begin
      state_reg <= state_next;
      instr_reg <= instr_next;
      pc_reg    <= pc_next;
      valid_reg <= valid_next;
      count_reg <= count_next;
    end
  end

  assign decInstruction = instr_reg;
  assign dec_pc         = pc_reg;
  assign dec_valid      = valid_reg;
  assign stall_count    = count_reg;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: two configurations side by side, directed table, corner
// sequences and randomized traffic against a cycle-level reference model.
`timescale 1ns/1ps

module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h8B1F03FF;

  logic        clk = 1'b0;
  logic        reset, br_redirect, ex_mem_read;
  logic [31:0] instruction;
  logic [63:0] noBrPC;
  logic [4:0]  ex_rd;

  logic [31:0] a_instr, b_instr;
  logic [63:0] a_pc, b_pc;
  logic        a_valid, b_valid, a_pcwe, b_pcwe, a_bubble, b_bubble;
  logic [1:0]  a_sc, b_sc;

  always #5 clk = ~clk;

  if_id_stage #(.STALL_CYCLES(1), .FLUSH_ON_BRANCH(0)) u_base (
    .clk(clk), .reset(reset), .instruction(instruction), .noBrPC(noBrPC),
    .br_redirect(br_redirect), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .decInstruction(a_instr), .dec_pc(a_pc), .dec_valid(a_valid),
    .pc_write_en(a_pcwe), .bubble(a_bubble), .stall_count(a_sc)
  );

  if_id_stage #(.STALL_CYCLES(3), .FLUSH_ON_BRANCH(1)) u_alt (
    .clk(clk), .reset(reset), .instruction(instruction), .noBrPC(noBrPC),
    .br_redirect(br_redirect), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .decInstruction(b_instr), .dec_pc(b_pc), .dec_valid(b_valid),
    .pc_write_en(b_pcwe), .bubble(b_bubble), .stall_count(b_sc)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per configuration, the decode slot plus how many forced
  // stall cycles remain before hazards are looked at again.
  int          cfg_stall [2] = '{1, 3};
  bit          cfg_flush [2] = '{1'b0, 1'b1};
  string       cfg_name  [2] = '{"base", "alt"};
  logic [31:0] m_instr [2];
  logic [63:0] m_pc    [2];
  bit          m_valid [2];
  int          m_left  [2];
  bit          m_known = 1'b0;
  logic        pre_pcwe [2];
  logic        pre_bub  [2];

  function automatic bit reads_reg(logic [31:0] ins, logic [4:0] r);
    bit uses_rt;
    uses_rt = (ins[31:24] == 8'hB4) || (ins[31:21] == 11'h7C0);
    return (ins[9:5] == r) || (ins[20:16] == r) || (uses_rt && ins[4:0] == r);
  endfunction

  function automatic bit m_stalls(int k);
    if (m_left[k] > 0) return 1'b1;
    return m_valid[k] && ex_mem_read && (ex_rd != 5'd31) && reads_reg(m_instr[k], ex_rd);
  endfunction

  task automatic sample(int k, output logic [31:0] ins, output logic [63:0] pc,
                        output logic v, output logic pcwe, output logic bub,
                        output logic [1:0] sc);
    if (k == 0) begin
      ins = a_instr; pc = a_pc; v = a_valid; pcwe = a_pcwe; bub = a_bubble; sc = a_sc;
    end else begin
      ins = b_instr; pc = b_pc; v = b_valid; pcwe = b_pcwe; bub = b_bubble; sc = b_sc;
    end
  endtask

  task automatic step(bit rst, logic [31:0] ins, logic [63:0] pc, bit br, bit mr, logic [4:0] rd);
    logic [31:0] s_ins;
    logic [63:0] s_pc;
    logic        s_v, s_pcwe, s_bub;
    logic [1:0]  s_sc;
    bit          stall_now [2];
    reset = rst; instruction = ins; noBrPC = pc; br_redirect = br; ex_mem_read = mr; ex_rd = rd;
    #2;
    for (int k = 0; k < 2; k++) begin
      sample(k, s_ins, s_pc, s_v, s_pcwe, s_bub, s_sc);
      pre_pcwe[k] = s_pcwe;
      pre_bub[k]  = s_bub;
      stall_now[k] = m_stalls(k);
      if (m_known) begin
        check({cfg_name[k], " pc_write_en"}, 64'(s_pcwe), 64'(!stall_now[k]));
        check({cfg_name[k], " bubble"}, 64'(s_bub), 64'(stall_now[k]));
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_instr[k] = NOP; m_pc[k] = 64'd0; m_valid[k] = 1'b0; m_left[k] = 0;
      end else if (m_left[k] > 0) begin
        m_left[k]--;
      end else if (stall_now[k]) begin
        m_left[k] = cfg_stall[k] - 1;
      end else if (cfg_flush[k] && br) begin
        m_instr[k] = NOP; m_pc[k] = pc; m_valid[k] = 1'b0;
      end else begin
        m_instr[k] = ins; m_pc[k] = pc; m_valid[k] = 1'b1;
      end
    end
    if (rst) m_known = 1'b1;
    #1;
    if (m_known) begin
      for (int k = 0; k < 2; k++) begin
        sample(k, s_ins, s_pc, s_v, s_pcwe, s_bub, s_sc);
        check({cfg_name[k], " decInstruction"}, 64'(s_ins), 64'(m_instr[k]));
        check({cfg_name[k], " dec_pc"}, s_pc, m_pc[k]);
        check({cfg_name[k], " dec_valid"}, 64'(s_v), 64'(m_valid[k]));
        check({cfg_name[k], " stall_count"}, 64'(s_sc), 64'(m_left[k]));
      end
    end
  endtask

  // Directed vectors for the base configuration (1 stall cycle, no flush).
  typedef struct {
    bit          rst;
    logic [31:0] ins;
    logic [63:0] pc;
    bit          br;
    bit          mr;
    logic [4:0]  rd;
    bit          chk_comb;
    bit          exp_pcwe;
    logic [31:0] exp_instr;
    logic [63:0] exp_pc;
    bit          exp_valid;
  } vec_t;

  function automatic vec_t mk(bit rst, logic [31:0] ins, logic [63:0] pc, bit br, bit mr,
                              logic [4:0] rd, bit cc, bit pcwe, logic [31:0] ei,
                              logic [63:0] ep, bit ev);
    vec_t v;
    v.rst = rst; v.ins = ins; v.pc = pc; v.br = br; v.mr = mr; v.rd = rd;
    v.chk_comb = cc; v.exp_pcwe = pcwe; v.exp_instr = ei; v.exp_pc = ep; v.exp_valid = ev;
    return v;
  endfunction

  function automatic logic [4:0] rand_reg();
    return ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    case ($urandom_range(0, 3))
      0:       return 32'h8B000000 | (32'(rand_reg()) << 16) | (32'(rand_reg()) << 5) | 32'(rand_reg());
      1:       return 32'hF8000000 | (32'(rand_reg()) << 5) | 32'(rand_reg());
      2:       return 32'hB4000000 | (32'($urandom_range(0, 7)) << 5) | 32'(rand_reg());
      default: return $urandom();
    endcase
  endfunction

  localparam logic [31:0] ADD_X2_X1_X3 = 32'h8B030022;
  localparam logic [31:0] ADD_X5_X6_X7 = 32'h8B0700C5;
  localparam logic [31:0] STUR_X5_X6   = 32'hF80000C5;
  localparam logic [31:0] CBZ_X31      = 32'hB400005F;
  localparam logic [31:0] CBZ_X9       = 32'hB4000009;
  localparam logic [31:0] I1 = 32'h8B020020, I2 = 32'h8B040062, I3 = 32'h8B0600A4;

  vec_t tbl [15];

  initial begin
    reset = 1'b0; instruction = '0; noBrPC = '0; br_redirect = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    @(posedge clk); #1;

    tbl[0]  = mk(1, 32'hFFFFFFFF, 64'h44, 0, 0, 0,  0, 1, NOP, 0, 0);
    tbl[1]  = mk(1, 32'hFFFFFFFF, 64'h44, 0, 0, 0,  1, 1, NOP, 0, 0);
    tbl[2]  = mk(0, I1, 4, 0, 0, 0,                 1, 1, I1, 4, 1);
    tbl[3]  = mk(0, I2, 8, 0, 0, 0,                 1, 1, I2, 8, 1);
    tbl[4]  = mk(0, I3, 12, 0, 0, 0,                1, 1, I3, 12, 1);
    tbl[5]  = mk(0, ADD_X2_X1_X3, 16, 0, 0, 0,      1, 1, ADD_X2_X1_X3, 16, 1);
    tbl[6]  = mk(0, ADD_X5_X6_X7, 20, 0, 1, 1,      1, 0, ADD_X2_X1_X3, 16, 1);
    tbl[7]  = mk(0, ADD_X5_X6_X7, 20, 0, 0, 1,      1, 1, ADD_X5_X6_X7, 20, 1);
    tbl[8]  = mk(0, STUR_X5_X6, 24, 0, 1, 5,        1, 1, STUR_X5_X6, 24, 1);
    tbl[9]  = mk(0, CBZ_X31, 28, 0, 1, 5,           1, 0, STUR_X5_X6, 24, 1);
    tbl[10] = mk(0, CBZ_X31, 28, 0, 0, 5,           1, 1, CBZ_X31, 28, 1);
    tbl[11] = mk(0, CBZ_X9, 32, 1, 1, 31,           1, 1, CBZ_X9, 32, 1);
    tbl[12] = mk(0, I1, 36, 1, 1, 9,                1, 0, CBZ_X9, 32, 1);
    tbl[13] = mk(0, I1, 36, 0, 0, 9,                1, 1, I1, 36, 1);
    tbl[14] = mk(1, I2, 40, 0, 0, 0,                1, 1, NOP, 0, 0);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].ins, tbl[i].pc, tbl[i].br, tbl[i].mr, tbl[i].rd);
      if (tbl[i].chk_comb) begin
        check($sformatf("vec%0d pc_write_en", i), 64'(pre_pcwe[0]), 64'(tbl[i].exp_pcwe));
        check($sformatf("vec%0d bubble", i), 64'(pre_bub[0]), 64'(!tbl[i].exp_pcwe));
      end
      check($sformatf("vec%0d decInstruction", i), 64'(a_instr), 64'(tbl[i].exp_instr));
      check($sformatf("vec%0d dec_pc", i), a_pc, tbl[i].exp_pc);
      check($sformatf("vec%0d dec_valid", i), 64'(a_valid), 64'(tbl[i].exp_valid));
    end

    // Three-cycle load-use stall on the alt instance.
    step(0, ADD_X2_X1_X3, 16, 0, 0, 0);
    step(0, ADD_X5_X6_X7, 20, 0, 1, 1);
    check("s3 hazard pc_write_en", 64'(pre_pcwe[1]), 64'(0));
    check("s3 count after 1", 64'(b_sc), 64'(2));
    check("s3 held instr", 64'(b_instr), 64'(ADD_X2_X1_X3));
    step(0, ADD_X5_X6_X7, 20, 0, 0, 1);
    check("s3 stall2 pc_write_en", 64'(pre_pcwe[1]), 64'(0));
    check("s3 count after 2", 64'(b_sc), 64'(1));
    step(0, ADD_X5_X6_X7, 20, 0, 0, 1);
    check("s3 stall3 bubble", 64'(pre_bub[1]), 64'(1));
    check("s3 count after 3", 64'(b_sc), 64'(0));
    check("s3 still held", 64'(b_instr), 64'(ADD_X2_X1_X3));
    step(0, ADD_X5_X6_X7, 20, 0, 0, 1);
    check("s3 resume pc_write_en", 64'(pre_pcwe[1]), 64'(1));
    check("s3 resume instr", 64'(b_instr), 64'(ADD_X5_X6_X7));

    // Redirect: alt squashes the slot, base lets it through.
    step(0, I1, 24, 1, 0, 0);
    check("flush instr", 64'(b_instr), 64'(NOP));
    check("flush valid", 64'(b_valid), 64'(0));
    check("flush dec_pc", b_pc, 64'd24);
    check("noflush instr", 64'(a_instr), 64'(I1));
    step(0, I2, 28, 0, 0, 0);
    check("post-flush load", 64'(b_instr), 64'(I2));

    // Hazard and redirect together: stall wins, no squash.
    step(0, CBZ_X9, 32, 1, 1, 3);
    check("hz+br pc_write_en", 64'(pre_pcwe[1]), 64'(0));
    check("hz+br instr kept", 64'(b_instr), 64'(I2));
    check("hz+br valid kept", 64'(b_valid), 64'(1));
    step(0, CBZ_X9, 32, 0, 0, 3);
    step(0, CBZ_X9, 32, 0, 0, 3);
    step(0, CBZ_X9, 32, 0, 0, 3);
    check("hz+br resume", 64'(b_instr), 64'(CBZ_X9));

    // Reset during the second stall cycle aborts the stall.
    step(0, ADD_X2_X1_X3, 16, 0, 0, 0);
    step(0, ADD_X5_X6_X7, 20, 0, 1, 1);
    step(1, ADD_X5_X6_X7, 20, 0, 0, 1);
    check("rst-stall pc_write_en", 64'(b_pcwe), 64'(1));
    check("rst-stall count", 64'(b_sc), 64'(0));
    check("rst-stall instr", 64'(b_instr), 64'(NOP));

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) == 0), rand_instr(), 64'($urandom()) << 2,
           ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, rand_reg());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
